// File: rtl/period_meter_pkg.sv
// Shared types and constants for the period meter and its divided-clock source.
package period_meter_pkg;

  typedef enum logic {IDLE, MEASURE} meter_state_t;

  // Divider terminal count used by the display refresh toggle.
  localparam int unsigned DIV_COUNT = 200000;

  // A toggle divider with terminal count N produces a period of 2*(N+1) cycles.
  function automatic int unsigned divider_period(input int unsigned count);
    return 2 * (count + 1);
  endfunction

  localparam int unsigned MAX_PERIOD_DEF = divider_period(DIV_COUNT);

endpackage

// File: rtl/module_sync_edge.sv
// Two-flop synchroniser plus one delay flop; yields the synced level and
// single-cycle rise/fall pulses. Reusable for buttons and keypad lines.
module module_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync_p0, sync_p1, sync_p2;

  // p0/p1: metastability chain, p2: previous synced level for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign level = sync_p1;
  assign rise  = sync_p1 & ~sync_p2;
  assign fall  = ~sync_p1 & sync_p2;

endmodule

// File: rtl/module_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk
// cycles, with a one-cycle result strobe and a loss-of-input timeout.
module module_period_meter
  import period_meter_pkg::*;
#(
  parameter  int unsigned MAX_PERIOD = MAX_PERIOD_DEF,
  localparam int unsigned W          = $clog2(MAX_PERIOD + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sig_in,
  output logic [W-1:0] period_o,
  output logic [W-1:0] high_o,
  output logic         valid_o,
  output logic         timeout_o
);

  localparam logic [W-1:0] ONE      = W'(1);
  localparam logic [W-1:0] LAST_CNT = W'(MAX_PERIOD - 1);

  logic         rise, fall;
  logic         level_unused;
  meter_state_t state;
  logic [W-1:0] cnt;
  logic [W-1:0] high_pend;

  module_sync_edge u_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (sig_in),
    .level (level_unused),
    .rise  (rise),
    .fall  (fall)
  );

  // Result registers: edges from the synchroniser land here one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      high_pend <= '0;
      period_o  <= '0;
      high_o    <= '0;
      valid_o   <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (rise) state <= MEASURE;
        end
        MEASURE: begin
          if (rise) begin
            period_o  <= cnt + ONE;
            high_o    <= high_pend;
            valid_o   <= 1'b1;
            timeout_o <= 1'b0;
            cnt       <= '0;
          end else if (cnt == LAST_CNT) begin
            // A rise on this same cycle would still have been accepted above.
            state     <= IDLE;
            timeout_o <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + ONE;
            if (fall) high_pend <= cnt + ONE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_module_period_meter.sv
// Bench for module_period_meter: a default-size instance and a MAX_PERIOD=20
// instance, checked against a timestamp-based model plus literal expectations.
module tb_module_period_meter;

  localparam int MAXB = 400002;
  localparam int MAXS = 20;
  localparam int WB   = $clog2(MAXB + 1);
  localparam int WS   = $clog2(MAXS + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    sig = 2'b00;
  logic [WB-1:0] period_b, high_b;
  logic          valid_b, to_b;
  logic [WS-1:0] period_s, high_s;
  logic          valid_s, to_s;

  module_period_meter #(.MAX_PERIOD(MAXB)) dut_big (
    .clk(clk), .rst(rst), .sig_in(sig[0]),
    .period_o(period_b), .high_o(high_b), .valid_o(valid_b), .timeout_o(to_b)
  );

  module_period_meter #(.MAX_PERIOD(MAXS)) dut_small (
    .clk(clk), .rst(rst), .sig_in(sig[1]),
    .period_o(period_s), .high_o(high_s), .valid_o(valid_s), .timeout_o(to_s)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int out_p(input int i);
    return (i == 0) ? int'(period_b) : int'(period_s);
  endfunction
  function automatic int out_h(input int i);
    return (i == 0) ? int'(high_b) : int'(high_s);
  endfunction
  function automatic int out_v(input int i);
    return (i == 0) ? int'(valid_b) : int'(valid_s);
  endfunction
  function automatic int out_t(input int i);
    return (i == 0) ? int'(to_b) : int'(to_s);
  endfunction
  function automatic int max_of(input int i);
    return (i == 0) ? MAXB : MAXS;
  endfunction

  // Model: timestamps of input edges as sampled at each clock edge; an edge
  // sampled at edge C takes effect on the outputs visible after edge C+2.
  int ecnt = 0;
  bit prev[2];
  bit rd1[2], rd2[2], fd1[2], fd2[2];
  bit armed[2];
  int last_r[2], fall_t[2];
  int exp_p[2], exp_h[2];
  bit exp_v[2], exp_t[2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        prev[i] = 0; rd1[i] = 0; rd2[i] = 0; fd1[i] = 0; fd2[i] = 0;
        armed[i] = 0; last_r[i] = 0; fall_t[i] = 0;
        exp_p[i] = 0; exp_h[i] = 0; exp_v[i] = 0; exp_t[i] = 0;
      end
    end else begin
      ecnt++;
      for (int i = 0; i < 2; i++) begin
        bit cur, r, f;
        int c;
        cur = sig[i];
        r = rd2[i];
        f = fd2[i];
        rd2[i] = rd1[i]; fd2[i] = fd1[i];
        rd1[i] = cur & ~prev[i];
        fd1[i] = ~cur & prev[i];
        prev[i] = cur;
        c = ecnt - 2;
        exp_v[i] = 0;
        if (r) begin
          if (armed[i]) begin
            exp_p[i] = c - last_r[i];
            exp_h[i] = fall_t[i] - last_r[i];
            exp_v[i] = 1;
            exp_t[i] = 0;
          end
          armed[i] = 1;
          last_r[i] = c;
        end else if (armed[i] && (c - last_r[i] == max_of(i))) begin
          armed[i] = 0;
          exp_t[i] = 1;
        end else if (f && armed[i]) begin
          fall_t[i] = c;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        check(i == 0 ? "big.period"  : "small.period",  out_p(i), exp_p[i]);
        check(i == 0 ? "big.high"    : "small.high",    out_h(i), exp_h[i]);
        check(i == 0 ? "big.valid"   : "small.valid",   out_v(i), int'(exp_v[i]));
        check(i == 0 ? "big.timeout" : "small.timeout", out_t(i), int'(exp_t[i]));
      end
    end
  end

  int nstb[2]   = '{0, 0};
  int stb_t[2]  = '{0, 0};
  int stb_pt[2] = '{0, 0};

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (out_v(i) == 1) begin
          nstb[i]++;
          stb_pt[i] = stb_t[i];
          stb_t[i]  = ecnt;
        end
      end
    end
  end

  task automatic drive(input int i, input bit v, input int n);
    sig[i] = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic wave(input int i, input int p, input int h, input int reps);
    repeat (reps) begin
      drive(i, 1'b1, h);
      drive(i, 1'b0, p - h);
    end
  endtask

  task automatic wait_strobe(input int i, input int ep, input int eh,
                             input int budget, input string tag);
    bit seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (out_v(i) == 1) seen = 1;
    end
    if (!seen) check({tag, ".strobe_seen"}, 0, 1);
    else begin
      check({tag, ".period"}, out_p(i), ep);
      check({tag, ".high"},   out_h(i), eh);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check({tag, ".period"},  out_p(i), 0);
      check({tag, ".high"},    out_h(i), 0);
      check({tag, ".valid"},   out_v(i), 0);
      check({tag, ".timeout"}, out_t(i), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  int base;

  initial begin
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Nominal 10/5 on the default-size instance.
    base = nstb[0];
    fork
      wave(0, 10, 5, 4);
      begin
        wait_strobe(0, 10, 5, 30, "nom1");
        wait_strobe(0, 10, 5, 15, "nom2");
        wait_strobe(0, 10, 5, 15, "nom3");
      end
    join
    check("nom.strobe_count", nstb[0] - base, 3);
    drive(0, 1'b0, 5);

    // Latency: rise driven now, strobe visible on the third falling edge.
    sig[0] = 1'b1;
    @(negedge clk); check("lat.n1.valid", out_v(0), 0);
    @(negedge clk); check("lat.n2.valid", out_v(0), 0);
    @(negedge clk); check("lat.n3.valid", out_v(0), 1);
    check("lat.period", out_p(0), 15);
    check("lat.high",   out_h(0), 5);
    drive(0, 1'b1, 2);
    drive(0, 1'b0, 5);

    // Fastest input: toggle every cycle.
    fork
      wave(0, 2, 1, 6);
      begin
        wait_strobe(0, 10, 5, 6, "fast0");
        repeat (5) wait_strobe(0, 2, 1, 4, "fast");
      end
    join
    check("fast.spacing", stb_t[0] - stb_pt[0], 2);

    // Asymmetric duty 7/2.
    fork
      wave(0, 7, 2, 4);
      begin
        wait_strobe(0, 3, 1, 6, "asym0");
        repeat (3) wait_strobe(0, 7, 2, 10, "asym");
      end
    join

    // Timeout on the MAX_PERIOD=20 instance.
    fork
      wave(1, 10, 5, 2);
      wait_strobe(1, 10, 5, 30, "to_pre");
    join
    drive(1, 1'b0, 12);
    check("to.before", out_t(1), 0);
    @(negedge clk);
    check("to.set",    out_t(1), 1);
    check("to.period", out_p(1), 10);
    check("to.high",   out_h(1), 5);
    base = nstb[1];
    fork
      wave(1, 10, 5, 2);
      wait_strobe(1, 10, 5, 30, "restart");
      begin
        repeat (8) @(negedge clk);
        check("to.hold", out_t(1), 1);
      end
    join
    check("restart.strobe_count", nstb[1] - base, 1);
    check("to.cleared", out_t(1), 0);
    drive(1, 1'b0, 15);

    // Limit: rises 20 apart accepted, 21 apart time out.
    base = nstb[1];
    fork
      begin
        drive(1, 1'b1, 10); drive(1, 1'b0, 10);
        drive(1, 1'b1, 10); drive(1, 1'b0, 11);
        drive(1, 1'b1, 5);  drive(1, 1'b0, 5);
      end
      begin
        wait_strobe(1, 20, 10, 30, "limit20");
        check("limit20.no_timeout", out_t(1), 0);
        repeat (20) @(negedge clk);
        check("limit21.timeout", out_t(1), 1);
        check("limit21.strobe_count", nstb[1] - base, 1);
      end
    join

    // Reset in the middle of a measurement.
    wave(0, 10, 5, 2);
    sig[0] = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    sig[0] = 1'b0;
    base = nstb[0];
    fork
      wave(0, 10, 5, 3);
      wait_strobe(0, 10, 5, 30, "after_rst");
    join
    check("after_rst.strobe_count", nstb[0] - base, 2);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/module_period_meter.md
# module_period_meter

Measures the waveform produced by the team's divided-clock generators, for example the 200000-count display refresh toggle. It resynchronises a slow square-wave input into the `clk` domain and measures its period and high time in `clk` cycles. Each complete cycle produces one result, published with a one-cycle valid strobe. Loss of the input is flagged by a timeout. The block sits on the self-check and debug path beside the divider and feeds LEDs or a readout.

## Interface
- `MAX_PERIOD`, default 400002: largest accepted period in `clk` cycles. This equals 2×(200000+1), the period of the default divider output.
- `W`, default `$clog2(MAX_PERIOD+1)`: result width. It is a localparam and is not overridable.
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst`, input, 1: reset. It is asynchronous and active-high.
- `sig_in`, input, 1: measured signal. It is asynchronous to `clk`.
- `period_o`, output, W: last measured period in cycles.
- `high_o`, output, W: high time of the same cycle, in cycles.
- `valid_o`, output, 1: one-cycle strobe. It is high when `period_o`/`high_o` update.
- `timeout_o`, output, 1: level. It is high while no valid edge has been seen within `MAX_PERIOD`.

## Operation
- **Input path:** `sig_in` passes through a 2-FF synchroniser, giving `s2`, then a 1-FF delay, giving `s3`.
  - `rise` = `s2 & ~s3`.
  - `fall` = `~s2 & s3`.
  - No glitch filtering.
- **State machine:** states `IDLE` and `MEASURE`. Reset enters `IDLE`.
- **`IDLE`:**
  - `cnt` is held at 0.
  - On `rise`: go to `MEASURE`, `cnt`←0, no `valid_o`. The first edge only arms the measurement.
- **`MEASURE`:**
  - `cnt` increments every cycle without `rise`.
  - On `fall`: `high_pend`←`cnt`+1.
  - On `rise`:
    - `period_o`←`cnt`+1 and `high_o`←`high_pend`.
    - `valid_o`=1 next cycle, `timeout_o`←0.
    - `cnt`←0. Stay in `MEASURE`.
  - Timeout occurs when `cnt` = `MAX_PERIOD`−1 and there is no `rise`:
    - Go to `IDLE` and set `timeout_o`←1.
    - `period_o`/`high_o` keep their last values, with no strobe.
- **Result definition:** rises P cycles apart yield `period_o`=P. A fall F cycles after the rise yields `high_o`=F.
- **Boundary cases:**
  - A rise exactly at `cnt` = `MAX_PERIOD`−1 is a valid measurement (period = `MAX_PERIOD`) and has priority over the timeout.
  - No fall within a period (input stuck high between rises is impossible; two rises imply a fall). `high_pend` always holds the latest fall in the current cycle.
  - `rise` and `fall` never coincide.
  - All arithmetic is unsigned W bits. `cnt` never exceeds `MAX_PERIOD`−1, so there is no wrap.
- **Reset mid-measurement:** any assertion of `rst` aborts the measurement, returns to `IDLE` and discards `high_pend`. The next measurement needs two new rises.

## Timing
- **Reset values:**
  - `period_o`=0, `high_o`=0, `valid_o`=0.
  - `timeout_o`=0.
  - Synchroniser flops and `cnt` = 0. State = `IDLE`.
- **Latency:**
  - A `sig_in` rise captured at `clk` edge N asserts `rise` in the cycle after edge N+1.
  - `valid_o` and the new outputs are registered at edge N+2, so they are visible 2 cycles after capture.
- **Output behaviour:**
  - `valid_o` is high for exactly one cycle per accepted period.
  - There is no backpressure; a consumer must sample on the strobe.
- **Rates:**
  - Minimum measurable period is 2 cycles, with a high time of 1.
  - Back-to-back strobes are at least 2 cycles apart.

## Structure
- **Package `period_meter_pkg`:**
  - `typedef enum logic {IDLE, MEASURE} meter_state_t`.
  - Default `MAX_PERIOD` constant, shared with the divider's count parameter (2×(count+1)).
- **Sub-module `module_sync_edge`:** 2-FF synchroniser plus edge register. Outputs `level`, `rise` and `fall`. It is reusable for button and keypad inputs.
- **Top:** FSM, counter, result registers.

## Test plan
- **Nominal square wave:** period 10, high 5, MAX_PERIOD=400002. The first rise gives no strobe. Each later rise gives `valid_o` with `period_o`=10 and `high_o`=5, arriving 2 cycles after the captured edge.
- **Fastest input:** `sig_in` toggling every cycle. Every rise strobes with `period_o`=2 and `high_o`=1, with strobes every 2 cycles.
- **Timeout:** MAX_PERIOD=20 with the input stopped after a 10-cycle period.
  - `timeout_o` rises 20 cycles after the last rise and outputs keep 10/5.
  - On restart, the first rise gives no strobe. The second strobes and clears `timeout_o`.
- **Limit:** MAX_PERIOD=20 with rises exactly 20 apart gives a strobe with `period_o`=20 and no timeout. Rises 21 apart give a timeout and no strobe.
- **Asymmetric duty:** period 7, high 2. The bench checks `period_o`=7 and `high_o`=2 for three consecutive strobes.
- **Reset mid-measurement:** `rst` pulsed during a measurement.
  - All outputs go to 0 immediately (asynchronously).
  - After release, two rises are needed before the first strobe, whose values are correct.
